// File: rtl/ysyx_040066_mem_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, requester
// identities and the default watchdog limit.
package ysyx_040066_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRD  = 2'd1,
        ST_DRD  = 2'd2,
        ST_DWR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INS  = 2'd1,
        OWN_RD   = 2'd2,
        OWN_WR   = 2'd3
    } owner_t;

    localparam logic [2:0] LEN_WORD        = 3'b011;
    localparam int         DEFAULT_TIMEOUT = 255;

    function automatic owner_t owner_of(state_t s);
        case (s)
            ST_IRD:  return OWN_INS;
            ST_DRD:  return OWN_RD;
            ST_DWR:  return OWN_WR;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_040066_mem_wdog.sv
// Watchdog for a granted transaction: counts busy cycles since the grant or
// the last mem_ready beat and flags expiry once TIMEOUT cycles have elapsed.
module ysyx_040066_mem_wdog
    import ysyx_040066_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            W  = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  TC = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable)
            count <= count + W'(1);
    end

    // Expiry fires in the TIMEOUT-th busy cycle so the owner sees the error
    // in that cycle and the FSM is back in IDLE on the next one.
    assign expire = enable && !clear && (count == TC);

endmodule

// File: rtl/ysyx_040066_mem_arbiter.sv
// Three-way arbiter sharing one memory port between icache reads, dcache
// reads and dcache writes; writes win, reads alternate round-robin.
module ysyx_040066_mem_arbiter
    import ysyx_040066_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ins_req,
    input  logic         ins_burst,
    input  logic [63:0]  ins_addr,
    output logic         ins_ready,
    output logic         ins_err,
    output logic         ins_last,
    output logic [63:0]  ins_data,
    input  logic         rd_req,
    input  logic         rd_burst,
    input  logic [2:0]   rd_len,
    input  logic [63:0]  rd_addr,
    output logic         rd_ready,
    output logic         rd_err,
    output logic         rd_last,
    output logic [63:0]  rd_data,
    input  logic         wr_req,
    input  logic         wr_burst,
    input  logic [2:0]   wr_len,
    input  logic [7:0]   wr_mask,
    input  logic [63:0]  wr_addr,
    input  logic [511:0] wr_data,
    output logic         wr_ready,
    output logic         wr_err,
    output logic         mem_req,
    output logic         mem_wen,
    output logic         mem_burst,
    output logic [2:0]   mem_len,
    output logic [7:0]   mem_mask,
    output logic [63:0]  mem_addr,
    output logic [511:0] mem_wdata,
    input  logic         mem_ready,
    input  logic         mem_err,
    input  logic         mem_last,
    input  logic [63:0]  mem_rdata
);

    state_t state;
    owner_t owner;
    logic   rr;
    logic   busy;
    logic   expire;
    logic   resp_ready;
    logic   resp_err;
    logic   resp_last;
    logic   done;

    assign owner = owner_of(state);
    assign busy  = (state != ST_IDLE);

    ysyx_040066_mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy || mem_ready),
        .enable (busy),
        .expire (expire)
    );

    always_comb begin
        mem_wen   = 1'b0;
        mem_burst = 1'b0;
        mem_len   = 3'b000;
        mem_mask  = 8'h00;
        mem_addr  = 64'h0;
        mem_wdata = 512'h0;
        case (state)
            ST_IRD: begin
                mem_addr  = ins_addr;
                mem_burst = ins_burst;
                mem_len   = LEN_WORD;
            end
            ST_DRD: begin
                mem_addr  = rd_addr;
                mem_burst = rd_burst;
                mem_len   = rd_len;
            end
            ST_DWR: begin
                mem_wen   = 1'b1;
                mem_addr  = wr_addr;
                mem_burst = wr_burst;
                mem_len   = wr_len;
                mem_mask  = wr_mask;
                mem_wdata = wr_data;
            end
            default: ;
        endcase
    end

    // An error beat swallows any simultaneous ready; a reset cycle reports nothing.
    assign resp_err   = busy && !rst && (mem_err || expire);
    assign resp_ready = busy && !rst && mem_ready && !mem_err;
    assign resp_last  = resp_ready && mem_last;
    assign done       = resp_err ||
                        (resp_ready && ((state == ST_DWR) || !mem_burst || mem_last));

    assign ins_ready = (owner == OWN_INS) && resp_ready;
    assign ins_err   = (owner == OWN_INS) && resp_err;
    assign ins_last  = (owner == OWN_INS) && resp_last;
    assign rd_ready  = (owner == OWN_RD)  && resp_ready;
    assign rd_err    = (owner == OWN_RD)  && resp_err;
    assign rd_last   = (owner == OWN_RD)  && resp_last;
    assign wr_ready  = (owner == OWN_WR)  && resp_ready;
    assign wr_err    = (owner == OWN_WR)  && resp_err;
    assign ins_data  = mem_rdata;
    assign rd_data   = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr      <= 1'b0;
            mem_req <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        state   <= ST_DWR;
                        mem_req <= 1'b1;
                    end else if (rd_req && (!ins_req || !rr)) begin
                        state   <= ST_DRD;
                        mem_req <= 1'b1;
                    end else if (ins_req) begin
                        state   <= ST_IRD;
                        mem_req <= 1'b1;
                    end
                end
                default: begin
                    if (done) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        // Hand priority to the other reader after any read grant.
                        if (state == ST_IRD)
                            rr <= 1'b0;
                        else if (state == ST_DRD)
                            rr <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_040066_mem_arbiter.sv
// Self-checking bench for ysyx_040066_mem_arbiter: a vector table of single
// transactions, hand-written multi-cycle sequences and a grant scoreboard.
module tb_ysyx_040066_mem_arbiter;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         ins_req, ins_burst;
    logic [63:0]  ins_addr;
    logic         ins_ready, ins_err, ins_last;
    logic [63:0]  ins_data;
    logic         rd_req, rd_burst;
    logic [2:0]   rd_len;
    logic [63:0]  rd_addr;
    logic         rd_ready, rd_err, rd_last;
    logic [63:0]  rd_data;
    logic         wr_req, wr_burst;
    logic [2:0]   wr_len;
    logic [7:0]   wr_mask;
    logic [63:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready, wr_err;
    logic         mem_req, mem_wen, mem_burst;
    logic [2:0]   mem_len;
    logic [7:0]   mem_mask;
    logic [63:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic         mem_ready, mem_err, mem_last;
    logic [63:0]  mem_rdata;

    always #5 clk = ~clk;

    ysyx_040066_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ins_req(ins_req), .ins_burst(ins_burst), .ins_addr(ins_addr),
        .ins_ready(ins_ready), .ins_err(ins_err), .ins_last(ins_last), .ins_data(ins_data),
        .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .rd_err(rd_err), .rd_last(rd_last), .rd_data(rd_data),
        .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_burst(mem_burst), .mem_len(mem_len),
        .mem_mask(mem_mask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_err(mem_err), .mem_last(mem_last), .mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic        mem_req_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every new grant must present the address queued for it.
    always @(negedge clk) begin
        if (mem_req && !mem_req_prev) begin
            if (exp_q.size() == 0)
                chk("sb_unexpected_grant", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            else
                chk("sb_grant_addr", mem_addr, exp_q.pop_front());
        end
        mem_req_prev = mem_req;
    end

    task automatic idle_inputs();
        ins_req = 0; ins_burst = 0; ins_addr = 64'h0;
        rd_req = 0; rd_burst = 0; rd_len = 3'b000; rd_addr = 64'h0;
        wr_req = 0; wr_burst = 0; wr_len = 3'b000; wr_mask = 8'h00;
        wr_addr = 64'h0; wr_data = 512'h0;
        mem_ready = 0; mem_err = 0; mem_last = 0; mem_rdata = 64'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        exp_q.delete();
    endtask

    task automatic wait_grant(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        chk(nm, mem_req, 1'b1);
    endtask

    // One single-beat response; reports which requester saw ready (3 = none).
    task automatic respond_single(output int who);
        @(posedge clk); #1;
        mem_ready = 1; mem_last = 0;
        @(negedge clk);
        who = ins_ready ? 0 : rd_ready ? 1 : wr_ready ? 2 : 3;
        @(posedge clk); #1;
        mem_ready = 0;
    endtask

    typedef struct {
        int          kind;      // 0 icache read, 1 dcache read, 2 dcache write
        logic        burst;
        logic [2:0]  len;
        logic [7:0]  mask;
        logic [63:0] addr;
        logic [63:0] data;
        logic        err_resp;  // respond with mem_err and mem_ready together
        logic [2:0]  e_len;
        logic        e_wen;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
        logic        e_ready;
        logic        e_err;
        logic        e_last;
    } vec_t;

    vec_t vt[6];

    initial begin
        vec_t v;
        int n, who, first_err, pulses, rdy_pulses, last_pulses;
        logic act_r, act_e, act_l, others, req16, req17;

        rst = 1;
        idle_inputs();

        vt[0] = '{0, 1'b0, 3'b111, 8'hFF, 64'h8000_0000, 64'h0, 1'b0,
                  3'b011, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0};
        vt[1] = '{0, 1'b1, 3'b000, 8'h00, 64'h8000_1000, 64'h0, 1'b0,
                  3'b011, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1, 1'b0, 3'b010, 8'h00, 64'h8000_2008, 64'h0, 1'b0,
                  3'b010, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0};
        vt[3] = '{1, 1'b1, 3'b011, 8'h00, 64'h8000_3000, 64'h0, 1'b1,
                  3'b011, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, 1'b0};
        vt[4] = '{2, 1'b0, 3'b011, 8'h0F, 64'h8000_4000, 64'hDEAD_BEEF_0123_4567, 1'b0,
                  3'b011, 1'b1, 8'h0F, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b0};
        vt[5] = '{2, 1'b1, 3'b011, 8'hFF, 64'h8000_5000, 64'h1122_3344_5566_7788, 1'b1,
                  3'b011, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 1'b0};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_len", {61'h0, mem_len}, 0);
        chk("rst_resp", {ins_ready, ins_err, rd_ready, rd_err, wr_ready, wr_err}, 0);

        // Table of single transactions
        for (int i = 0; i < 6; i++) begin
            v = vt[i];
            @(posedge clk); #1;
            case (v.kind)
                0: begin ins_req = 1; ins_burst = v.burst; ins_addr = v.addr; end
                1: begin rd_req = 1; rd_burst = v.burst; rd_len = v.len; rd_addr = v.addr; end
                default: begin
                    wr_req = 1; wr_burst = v.burst; wr_len = v.len; wr_mask = v.mask;
                    wr_addr = v.addr; wr_data = {448'h0, v.data};
                end
            endcase
            exp_q.push_back(v.addr);
            @(negedge clk);
            chk("vec_latency", mem_req, 0);
            @(posedge clk); #1;
            ins_req = 0; rd_req = 0; wr_req = 0;
            @(negedge clk);
            chk("vec_mem_req", mem_req, 1);
            chk("vec_mem_wen", mem_wen, v.e_wen);
            chk("vec_mem_len", {61'h0, mem_len}, {61'h0, v.e_len});
            chk("vec_mem_mask", {56'h0, mem_mask}, {56'h0, v.e_mask});
            chk("vec_mem_burst", mem_burst, v.burst);
            chk("vec_mem_wdata", mem_wdata[63:0], v.e_wdata);
            @(posedge clk); #1;
            mem_ready = 1; mem_err = v.err_resp; mem_last = v.burst;
            mem_rdata = 64'hA5A5_0000_0000_0000 | 64'(i);
            @(negedge clk);
            case (v.kind)
                0: begin act_r = ins_ready; act_e = ins_err; act_l = ins_last;
                         others = rd_ready | rd_err | wr_ready | wr_err | rd_last; end
                1: begin act_r = rd_ready; act_e = rd_err; act_l = rd_last;
                         others = ins_ready | ins_err | wr_ready | wr_err | ins_last; end
                default: begin act_r = wr_ready; act_e = wr_err; act_l = 1'b0;
                         others = ins_ready | ins_err | rd_ready | rd_err | ins_last | rd_last; end
            endcase
            chk("vec_ready", act_r, v.e_ready);
            chk("vec_err", act_e, v.e_err);
            if (v.kind != 2) chk("vec_last", act_l, v.e_last);
            chk("vec_nonowner_quiet", others, 0);
            chk("vec_rdata_pass", rd_data, 64'hA5A5_0000_0000_0000 | 64'(i));
            @(posedge clk); #1;
            mem_ready = 0; mem_err = 0; mem_last = 0;
            @(negedge clk);
            chk("vec_idle_req", mem_req, 0);
            chk("vec_idle_addr", mem_addr, 0);
        end

        // All three requesters at once: write, then dcache read, then icache read
        do_reset();
        ins_req = 1; ins_addr = 64'h8000_0100;
        rd_req = 1;  rd_addr = 64'h8000_0200; rd_len = 3'b011;
        wr_req = 1;  wr_addr = 64'h8000_0300; wr_len = 3'b011; wr_mask = 8'hFF;
        exp_q.push_back(64'h8000_0300);
        exp_q.push_back(64'h8000_0200);
        exp_q.push_back(64'h8000_0100);
        for (int g = 0; g < 3; g++) begin
            wait_grant("prio_grant", n);
            if (g == 0) chk("prio_first_latency", 64'(n), 2);
            respond_single(who);
            chk("prio_owner", 64'(who), 64'(2 - g));
            case (who)
                0: ins_req = 0;
                1: rd_req = 0;
                2: wr_req = 0;
                default: begin ins_req = 0; rd_req = 0; wr_req = 0; end
            endcase
            @(negedge clk);
            chk("prio_idle_gap", mem_req, 0);
        end

        // Continuous dcache and icache reads alternate D, I, D, I
        do_reset();
        ins_req = 1; ins_addr = 64'h8000_0A00;
        rd_req = 1;  rd_addr = 64'h8000_0B00; rd_len = 3'b011;
        for (int g = 0; g < 4; g++)
            exp_q.push_back((g % 2 == 0) ? 64'h8000_0B00 : 64'h8000_0A00);
        for (int g = 0; g < 4; g++) begin
            wait_grant("rr_grant", n);
            respond_single(who);
            chk("rr_owner", 64'(who), (g % 2 == 0) ? 64'd1 : 64'd0);
            if (g == 3) begin ins_req = 0; rd_req = 0; end
            @(negedge clk);
            chk("rr_idle_gap", mem_req, 0);
        end

        // 8-beat icache burst; requester drops req right after the grant
        do_reset();
        ins_req = 1; ins_burst = 1; ins_addr = 64'h8000_0040;
        exp_q.push_back(64'h8000_0040);
        wait_grant("burst_grant", n);
        ins_req = 0;
        rdy_pulses = 0; last_pulses = 0;
        for (int b = 1; b <= 8; b++) begin
            @(posedge clk); #1;
            mem_ready = 1; mem_last = (b == 8); mem_rdata = 64'h1000 + 64'(b);
            @(negedge clk);
            if (ins_ready) rdy_pulses++;
            if (ins_last) last_pulses++;
            if (b == 4) chk("burst_data", ins_data, 64'h1004);
        end
        @(posedge clk); #1;
        mem_ready = 0; mem_last = 0;
        @(negedge clk);
        chk("burst_ready_count", 64'(rdy_pulses), 8);
        chk("burst_last_count", 64'(last_pulses), 1);
        chk("burst_idle_after", mem_req, 0);

        // Watchdog: dcache read with no mem_ready ever
        do_reset();
        @(posedge clk); #1;
        rd_req = 1; rd_addr = 64'h8000_0C00; rd_len = 3'b011;
        exp_q.push_back(64'h8000_0C00);
        first_err = -1; pulses = 0; rdy_pulses = 0; req16 = 0; req17 = 1;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            if (rd_err) begin
                pulses++;
                if (first_err < 0) first_err = k;
            end
            if (rd_ready) rdy_pulses++;
            if (k == 16) req16 = mem_req;
            if (k == 17) req17 = mem_req;
            if (k == 1) rd_req = 0;
        end
        chk("wdog_err_cycle", 64'(first_err), 16);
        chk("wdog_err_pulses", 64'(pulses), 1);
        chk("wdog_no_ready", 64'(rdy_pulses), 0);
        chk("wdog_req_before", req16, 1);
        chk("wdog_req_after", req17, 0);

        // Reset on beat 3 of a burst, after a dcache read moved rr to the icache
        do_reset();
        rd_req = 1; rd_addr = 64'h8000_0D00; rd_len = 3'b011;
        exp_q.push_back(64'h8000_0D00);
        wait_grant("rstb_rd_grant", n);
        respond_single(who);
        rd_req = 0;
        chk("rstb_rd_owner", 64'(who), 1);
        @(posedge clk); #1;
        ins_req = 1; ins_burst = 1; ins_addr = 64'h8000_0E00;
        exp_q.push_back(64'h8000_0E00);
        wait_grant("rstb_ins_grant", n);
        ins_req = 0;
        for (int b = 1; b <= 2; b++) begin
            @(posedge clk); #1;
            mem_ready = 1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("rstb_beat3_quiet", {ins_ready, ins_err, ins_last, rd_ready, rd_err, wr_ready, wr_err}, 0);
        @(posedge clk); #1;
        rst = 0; mem_ready = 0;
        @(negedge clk);
        chk("rstb_mem_req", mem_req, 0);
        chk("rstb_resp", {ins_ready, ins_err, rd_ready, rd_err, wr_ready, wr_err}, 0);
        @(posedge clk); #1;
        ins_req = 1; ins_addr = 64'h8000_0F00;
        rd_req = 1;  rd_addr = 64'h8000_0D40;
        exp_q.push_back(64'h8000_0D40);
        wait_grant("rstb_rr_grant", n);
        chk("rstb_rr_dcache_first", mem_addr, 64'h8000_0D40);
        ins_req = 0; rd_req = 0;
        respond_single(who);
        @(negedge clk);
        chk("rstb_rr_idle", mem_req, 0);

        // Write with error and ready together
        do_reset();
        wr_req = 1; wr_addr = 64'h8000_0800; wr_len = 3'b011; wr_mask = 8'hF0;
        exp_q.push_back(64'h8000_0800);
        wait_grant("werr_grant", n);
        wr_req = 0;
        @(posedge clk); #1;
        mem_ready = 1; mem_err = 1;
        @(negedge clk);
        chk("werr_err", wr_err, 1);
        chk("werr_ready", wr_ready, 0);
        @(posedge clk); #1;
        mem_ready = 0; mem_err = 0;
        @(negedge clk);
        chk("werr_idle", mem_req, 0);

        repeat (2) @(negedge clk);
        chk("sb_leftover", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_040066_mem_arbiter.md
YSYX_040066_MEM_ARBITER -- requirements
Module: ysyx_040066_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles a granted transaction may wait between mem_ready beats.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- ins_req, ins_burst  in  1 each  icache read request; burst = 8-beat line.
- ins_addr  in  64  icache address.
- ins_ready, ins_err, ins_last  out  1 each  icache beat / error / last beat.
- ins_data  out  64  icache read beat.
- rd_req, rd_burst  in  1 each  dcache read request.
- rd_len  in  3  dcache size code.
- rd_addr  in  64  dcache read address.
- rd_ready, rd_err, rd_last  out  1 each  dcache beat / error / last beat.
- rd_data  out  64  dcache read beat.
- wr_req, wr_burst  in  1 each  dcache write request.
- wr_len  in  3  size code.
- wr_mask  in  8  byte mask.
- wr_addr  in  64  write address.
- wr_data  in  512  write line.
- wr_ready, wr_err  out  1 each  write done / error.
- mem_req, mem_wen, mem_burst  out  1 each  shared port request, write enable, burst.
- mem_len  out  3  size code.
- mem_mask  out  8  byte mask.
- mem_addr  out  64  shared address.
- mem_wdata  out  512  shared write data.
- mem_ready, mem_err, mem_last  in  1 each  shared port beat / error / last.
- mem_rdata  in  64  shared read beat.

Function
REQ-003 SHALL be an FSM with states IDLE, IRD, DRD, DWR; exactly one requester owns the memory port outside IDLE.
REQ-004 In IDLE, arbitration SHALL register the grant; mem_req SHALL rise the cycle after the requester's req (1-cycle latency) and stay high until the transaction ends.
REQ-005 Priority: wr_req first; among ins_req and rd_req, round-robin via 1-bit pointer rr (rr=0 favours dcache read); rr SHALL flip to the other requester on completion of every read grant.
REQ-006 Grant SHALL be held until completion: burst read ends on mem_ready&&mem_last; single read ends on mem_ready; write ends on mem_ready; any state ends on mem_err.
REQ-007 On completion the FSM SHALL return to IDLE; back-to-back grants therefore have one IDLE cycle between them.
REQ-008 IRD SHALL drive mem_addr=ins_addr, mem_burst=ins_burst, mem_len=3'b011, mem_wen=0, mem_mask=0.
REQ-009 DRD SHALL drive rd_addr, rd_burst, rd_len, mem_wen=0; DWR SHALL drive wr_addr, wr_burst, wr_len, wr_mask, wr_data, mem_wen=1.
REQ-010 mem_ready, mem_last, mem_err SHALL be routed combinationally to the owner only; non-owners see 0; ins_data/rd_data SHALL equal mem_rdata at all times.
REQ-011 In IDLE, mem_req, mem_wen, mem_burst SHALL be 0, mem_addr/mem_wdata/mem_mask/mem_len 0.
REQ-012 Watchdog counter SHALL clear on grant and on each mem_ready, increment otherwise while busy; on reaching TIMEOUT it SHALL pulse the owner's err for one cycle, drop mem_req, and return to IDLE.
REQ-013 A requester dropping req mid-transaction SHALL NOT abort the grant; the arbiter completes it against mem_ready.
REQ-014 mem_err with mem_ready in the same cycle SHALL be reported as err only (ready suppressed).

Reset
REQ-015 On rst: state=IDLE, rr=0, watchdog=0, all outputs 0 from the following cycle, including mid-transaction; no err pulse is generated.

Structure
REQ-016 Package ysyx_040066_mem_pkg SHALL hold the state enum, requester IDs, LEN_WORD=3'b011, default TIMEOUT.
REQ-017 Watchdog SHALL be sub-module ysyx_040066_mem_wdog (clear, enable, expire); arbitration and muxing stay in this module.

Verification
REQ-018 ins_req=rd_req=wr_req=1 at cycle 0 -> DWR granted cycle 1, then DRD, then IRD, each separated by one IDLE cycle.
REQ-019 ins_req and rd_req held continuously, single-beat, mem_ready next cycle -> grants alternate D,I,D,I.
REQ-020 ins_burst=1 at 0x8000_0040, mem_ready 8 beats, mem_last on beat 8 -> ins_ready 8 pulses, ins_last once, IDLE next cycle.
REQ-021 rd_req single, mem_ready never arrives, TIMEOUT=16 -> rd_err one-cycle pulse 16 cycles after grant, mem_req low after.
REQ-022 rst asserted on beat 3 of an 8-beat burst -> mem_req 0 next cycle, rr=0, no err/ready to any requester.
REQ-023 wr_req with mem_err=mem_ready=1 on first response -> wr_err=1, wr_ready=0, IDLE next cycle.
